bus8_autoclear_tmo: RTL and testbench
=====================================

Name: bus8_autoclear_tmo

Overview:
- Next-generation 8-bit-bus autoclear register block with 1..8 independent channels.
- Software starts and stops events, and reads live and history state as before.
- New: per-channel watchdog timeout, rising-edge done detection, sticky timeout flags with an interrupt mask, and a programmable timeout value.
- Sits on the 8-bit register bus between SW and the event-generating modules.

Parameters:
AC_BITS_USED, 2, channels implemented (1..8); bits at and above AC_BITS_USED read 0 and are ignored on write.
PRESCALE_DIV, 1000, clocks per timeout tick (>=2).
TMO_DEFAULT, 8'd100, reset value of the timeout register, in ticks.

Ports:
i_Bus_Clk  in  1  bus clock; the only clock.
i_Bus_Rst_L  in  1  synchronous, active-low reset.
i_Bus_CS  in  1  chip select; one access per asserted cycle.
i_Bus_Wr_Rd_n  in  1  1 = write, 0 = read.
i_Bus_Addr8  in  4  register offset.
i_Bus_Wr_Data  in  8  write data.
o_Bus_Rd_Data  out  8  read data.
o_Bus_Rd_DV  out  1  read data valid, one-cycle pulse.
o_AC_Start  out  AC_BITS_USED  per-channel busy level to event modules.
i_AC_Done  in  AC_BITS_USED  per-channel done, same clock domain.
o_Irq  out  1  OR of (timeout flags AND mask), registered.

Behaviour:
- Register map:
  - 0x0 Start (W)
  - 0x1 State (R)
  - 0x2 Stop (W)
  - 0x3 History (R)
  - 0x4 History Clear (W)
  - 0x5 Timeout Flags (R)
  - 0x6 Timeout Flag Clear (W)
  - 0x7 Timeout Value (R/W, 8 bits, ticks; 0 = watchdog disabled)
  - 0x8 Irq Mask (R/W)
- Write-1 semantics on 0x0, 0x2, 0x4, 0x6; zero bits have no effect. Writes to read-only or unmapped offsets are ignored.
- Reads:
  - Data and o_Bus_Rd_DV are valid on the cycle after the CS/read cycle.
  - Unused bits are zero-filled.
  - Write-only and unmapped offsets read 0x00.
- Reset (i_Bus_Rst_L=0 at a clock edge):
  - o_Bus_Rd_Data=0, o_Bus_Rd_DV=0, o_AC_Start=0, o_Irq=0.
  - State, history, flags, mask and all counters = 0.
  - Timeout Value = TMO_DEFAULT; prescaler = 0.
  - Reset mid-event aborts the event silently, with no flag set.
- Done detection: a rising edge only. i_AC_Done is registered once; done_evt = done & ~done_q. A level held high does not complete a later event.
- Per-channel FSM, IDLE/BUSY; o_AC_Start[i] = (state==BUSY).
  - IDLE -> BUSY on Start bit. Latency: the write is sampled at edge k and o_AC_Start is high from edge k. History bit is set.
  - BUSY -> IDLE on Stop bit, done_evt, or timeout expiry.
  - Start while BUSY: stays BUSY, tick counter restarts at 0 (retrigger).
- Same-cycle priority per channel: Start > Stop > done_evt > timeout. For example, Start coincident with done_evt leaves the channel BUSY with the counter at 0.
- History: set on Start; cleared by History Clear. Set wins if both occur in the same cycle.
- Watchdog:
  - Prescaler is free-running 0..PRESCALE_DIV-1; tick when it equals PRESCALE_DIV-1.
  - Per-channel 8-bit counter: cleared on entering or re-entering BUSY, increments on tick while BUSY, saturates.
  - Expiry when counter == Timeout Value, value != 0, and BUSY: channel goes IDLE and the flag bit is set (sticky).
  - Expiry therefore occurs between (N-1)*PRESCALE_DIV+1 and N*PRESCALE_DIV clocks after start.
  - Changing Timeout Value mid-event takes effect immediately. A value at or below the current count never expires that event (equality compare); Stop/done still apply.
- Flags: cleared by 0x6 write-1. Set wins over clear in the same cycle.
- o_Irq = |(flags & mask), registered one cycle after the flag/mask change.

Decomposition:
- Package/include bus8_autoclear_pkg: register offset localparams (0x0..0x8), FSM state encoding (IDLE=0, BUSY=1).
- Sub-module autoclear_tmo_channel: one instance per channel via generate. Contains the FSM, history bit, counter, flag and done edge detect. Inputs: start/stop/hist_clr/flag_clr pulses, tick, timeout value.
- Top level contains the bus decode, read mux, prescaler, mask and irq.

Test Plan:
- Basic start/done:
  - Write 0x0=0x01 -> o_AC_Start=01 from the sampling edge.
  - Read 0x1 -> 0x01 with DV one cycle later.
  - Pulse i_AC_Done[0] -> o_AC_Start=00 next edge; read 0x3 -> 0x01; write 0x4=0x01 -> 0x3 reads 0x00.
- Level done: hold i_AC_Done[1]=1, write 0x0=0x02 -> ch1 stays BUSY. Drop and re-raise done -> IDLE. Stop (0x2=0x02) on another run -> IDLE, no flag.
- Timeout (PRESCALE_DIV=4, 0x7=3, 0x8=0x01):
  - Start ch0, no done -> IDLE within 9..12 clocks.
  - 0x5 reads 0x01; o_Irq=1 one cycle later.
  - Write 0x6=0x01 -> flags 0, o_Irq=0. Same-cycle clear and expiry -> flag stays 1.
- Retrigger/priority: re-start ch0 at 2 ticks -> expiry measured from the re-start. Start coincident with a done edge -> BUSY. 0x7=0 -> never times out.
- Width: AC_BITS_USED=2, write 0x0=0xFF -> o_AC_Start=11; 0x1 reads 0x03; read 0xF -> 0x00 with DV.
- Reset mid-event: ch0 BUSY with counter>0, assert reset one cycle -> all outputs 0, 0x7 reads TMO_DEFAULT, 0x5 reads 0x00.

Source files
------------

// File: rtl/bus8_autoclear_pkg.sv
// Shared definitions for the bus8_autoclear_tmo block: register offsets and
// the per-channel FSM state encoding.
package bus8_autoclear_pkg;

   localparam logic [3:0] REG_START     = 4'h0;
   localparam logic [3:0] REG_STATE     = 4'h1;
   localparam logic [3:0] REG_STOP      = 4'h2;
   localparam logic [3:0] REG_HIST      = 4'h3;
   localparam logic [3:0] REG_HIST_CLR  = 4'h4;
   localparam logic [3:0] REG_FLAGS     = 4'h5;
   localparam logic [3:0] REG_FLAG_CLR  = 4'h6;
   localparam logic [3:0] REG_TMO       = 4'h7;
   localparam logic [3:0] REG_MASK      = 4'h8;

   localparam int TMO_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } ac_state_e;

endpackage

// File: rtl/bus8_autoclear_tmo_if.sv
// 8-bit register bus between software and the autoclear block.
interface bus8_autoclear_tmo_if;

   logic       i_Bus_CS;
   logic       i_Bus_Wr_Rd_n;
   logic [3:0] i_Bus_Addr8;
   logic [7:0] i_Bus_Wr_Data;
   logic [7:0] o_Bus_Rd_Data;
   logic       o_Bus_Rd_DV;

   modport master (
      output i_Bus_CS, i_Bus_Wr_Rd_n, i_Bus_Addr8, i_Bus_Wr_Data,
      input  o_Bus_Rd_Data, o_Bus_Rd_DV
   );

   modport slave (
      input  i_Bus_CS, i_Bus_Wr_Rd_n, i_Bus_Addr8, i_Bus_Wr_Data,
      output o_Bus_Rd_Data, o_Bus_Rd_DV
   );

endinterface

// File: rtl/autoclear_tmo_channel.sv
// One autoclear channel: IDLE/BUSY FSM with watchdog counter, history bit,
// sticky timeout flag and rising-edge done detection.
module autoclear_tmo_channel
   import bus8_autoclear_pkg::*;
(
   input  logic             i_Bus_Clk,
   input  logic             i_Bus_Rst_L,
   input  logic             start,
   input  logic             stop,
   input  logic             hist_clr,
   input  logic             flag_clr,
   input  logic             tick,
   input  logic [TMO_W-1:0] tmo_val,
   input  logic             done,
   output logic             busy,
   output logic             hist,
   output logic             flag
);

   ac_state_e        state, state_nxt;
   logic [TMO_W-1:0] cnt, cnt_nxt;
   logic [TMO_W:0]   cnt_inc;
   logic             done_q;
   logic             done_evt;
   logic             expire;
   logic             flag_set;

   assign done_evt = done & ~done_q;
   assign cnt_inc  = {1'b0, cnt} + 1'b1;

   // Expire on the tick that brings the count up to the timeout value, so a
   // value already at or below the count can never match for this event.
   assign expire = (state == ST_BUSY) && tick && (tmo_val != '0) &&
                   (cnt_inc == {1'b0, tmo_val});

   // NOTE: every variable gets a default before the branches, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      flag_set  = 1'b0;
      if (start) begin
         state_nxt = ST_BUSY;
         cnt_nxt   = '0;
      end else if (state == ST_BUSY) begin
         if (stop || done_evt) begin
            state_nxt = ST_IDLE;
         end else if (expire) begin
            state_nxt = ST_IDLE;
            flag_set  = 1'b1;
         end else if (tick && (cnt != '1)) begin
            cnt_nxt = cnt_inc[TMO_W-1:0];
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every flop in the design
   // updates from the same pre-edge values.
   always_ff @(posedge i_Bus_Clk) begin
      if (!i_Bus_Rst_L) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
         hist   <= 1'b0;
         flag   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         done_q <= done;
         hist   <= start | (hist & ~hist_clr);
         flag   <= flag_set | (flag & ~flag_clr);
      end
   end

   assign busy = (state == ST_BUSY);

endmodule

// File: rtl/bus8_autoclear_tmo.sv
// Autoclear register block: bus decode, read mux, timeout prescaler,
// interrupt mask and one watchdog channel per implemented bit.
module bus8_autoclear_tmo
   import bus8_autoclear_pkg::*;
#(
   parameter int               AC_BITS_USED = 2,
   parameter int               PRESCALE_DIV = 1000,
   parameter logic [TMO_W-1:0] TMO_DEFAULT  = 8'd100
)(
   input  logic                    i_Bus_Clk,
   input  logic                    i_Bus_Rst_L,
   bus8_autoclear_tmo_if.slave     bus,
   output logic [AC_BITS_USED-1:0] o_AC_Start,
   input  logic [AC_BITS_USED-1:0] i_AC_Done,
   output logic                    o_Irq
);

   localparam int              PS_W    = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

   typedef logic [AC_BITS_USED-1:0] ch_vec_t;

   logic             wr_en;
   logic             rd_en;
   ch_vec_t          wr_bits;
   ch_vec_t          start_p, stop_p, hclr_p, fclr_p;
   ch_vec_t          busy_v, hist_v, flag_v;
   ch_vec_t          mask_q;
   logic [TMO_W-1:0] tmo_q;
   logic [PS_W-1:0]  presc;
   logic             tick;
   logic [7:0]       rd_mux;
   logic [7:0]       rd_data_q;
   logic             rd_dv_q;
   logic             irq_q;

   function automatic logic [7:0] zext(input ch_vec_t v);
      logic [7:0] r;
      r = '0;
      r[AC_BITS_USED-1:0] = v;
      return r;
   endfunction

   assign wr_en   = bus.i_Bus_CS &  bus.i_Bus_Wr_Rd_n;
   assign rd_en   = bus.i_Bus_CS & ~bus.i_Bus_Wr_Rd_n;
   assign wr_bits = bus.i_Bus_Wr_Data[AC_BITS_USED-1:0];

   // Write-1 pulse decode; read-only and unmapped offsets fall through.
   always_comb begin
      start_p = '0;
      stop_p  = '0;
      hclr_p  = '0;
      fclr_p  = '0;
      if (wr_en) begin
         case (bus.i_Bus_Addr8)
            REG_START:    start_p = wr_bits;
            REG_STOP:     stop_p  = wr_bits;
            REG_HIST_CLR: hclr_p  = wr_bits;
            REG_FLAG_CLR: fclr_p  = wr_bits;
            default:      ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus.i_Bus_Addr8)
         REG_STATE: rd_mux = zext(busy_v);
         REG_HIST:  rd_mux = zext(hist_v);
         REG_FLAGS: rd_mux = zext(flag_v);
         REG_TMO:   rd_mux = tmo_q;
         REG_MASK:  rd_mux = zext(mask_q);
         default:   rd_mux = '0;
      endcase
   end

   assign tick = (presc == PS_LAST);

   always_ff @(posedge i_Bus_Clk) begin
      if (!i_Bus_Rst_L) begin
         presc     <= '0;
         tmo_q     <= TMO_DEFAULT;
         mask_q    <= '0;
         rd_data_q <= '0;
         rd_dv_q   <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + PS_W'(1);
         if (wr_en && (bus.i_Bus_Addr8 == REG_TMO))  tmo_q  <= bus.i_Bus_Wr_Data;
         if (wr_en && (bus.i_Bus_Addr8 == REG_MASK)) mask_q <= wr_bits;
         rd_dv_q   <= rd_en;
         rd_data_q <= rd_en ? rd_mux : '0;
         irq_q     <= |(flag_v & mask_q);
      end
   end

   for (genvar g = 0; g < AC_BITS_USED; g++) begin : g_ch
      autoclear_tmo_channel u_ch (
         .i_Bus_Clk   (i_Bus_Clk),
         .i_Bus_Rst_L (i_Bus_Rst_L),
         .start       (start_p[g]),
         .stop        (stop_p[g]),
         .hist_clr    (hclr_p[g]),
         .flag_clr    (fclr_p[g]),
         .tick        (tick),
         .tmo_val     (tmo_q),
         .done        (i_AC_Done[g]),
         .busy        (busy_v[g]),
         .hist        (hist_v[g]),
         .flag        (flag_v[g])
      );
   end

   assign o_AC_Start        = busy_v;
   assign o_Irq             = irq_q;
   assign bus.o_Bus_Rd_Data = rd_data_q;
   assign bus.o_Bus_Rd_DV   = rd_dv_q;

endmodule

// File: tb/tb_bus8_autoclear_tmo.sv
// Scoreboard bench for bus8_autoclear_tmo: directed scenarios then random
// bus/done traffic, checked against an edge-count arithmetic model.
module tb_bus8_autoclear_tmo;

   localparam int         N    = 2;
   localparam int         DIV  = 4;
   localparam logic [7:0] TDEF = 8'd100;

   logic         clk = 1'b0;
   logic         rst_l;
   logic [N-1:0] ac_start;
   logic [N-1:0] done_tb;
   logic         irq;

   bus8_autoclear_tmo_if bus ();

   bus8_autoclear_tmo #(
      .AC_BITS_USED (N),
      .PRESCALE_DIV (DIV),
      .TMO_DEFAULT  (TDEF)
   ) dut (
      .i_Bus_Clk   (clk),
      .i_Bus_Rst_L (rst_l),
      .bus         (bus),
      .o_AC_Start  (ac_start),
      .i_AC_Done   (done_tb),
      .o_Irq       (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit mon_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: edge j counts clocks since reset; a timeout tick falls on
   // every edge with j % DIV == 0, and a channel started at edge s has seen
   // j/DIV - s/DIV ticks by edge j.
   int unsigned m_j;
   int unsigned m_s [N];
   bit [N-1:0]  m_busy, m_hist, m_flag, m_mask, m_done_prev;
   logic [7:0]  m_tmo;
   bit          m_irq, m_dv;
   logic [7:0]  exp_q [$];

   bit          e_wr, e_rd, e_tick, e_set, e_evt;
   logic [3:0]  e_a;
   logic [7:0]  e_d;

   function automatic int unsigned ticks_between(int unsigned s, int unsigned e);
      return e / DIV - s / DIV;
   endfunction

   function automatic logic [7:0] model_read(input logic [3:0] a);
      case (a)
         4'h1:    return 8'(m_busy);
         4'h3:    return 8'(m_hist);
         4'h5:    return 8'(m_flag);
         4'h7:    return m_tmo;
         4'h8:    return 8'(m_mask);
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!rst_l) begin
         m_j = 0;
         m_busy = '0; m_hist = '0; m_flag = '0; m_mask = '0; m_done_prev = '0;
         m_tmo = TDEF; m_irq = 1'b0; m_dv = 1'b0;
         exp_q.delete();
      end else begin
         m_j++;
         e_tick = (m_j % DIV == 0);
         e_a  = bus.i_Bus_Addr8;
         e_d  = bus.i_Bus_Wr_Data;
         e_wr = bus.i_Bus_CS &&  bus.i_Bus_Wr_Rd_n;
         e_rd = bus.i_Bus_CS && !bus.i_Bus_Wr_Rd_n;
         m_dv = e_rd;
         if (e_rd) exp_q.push_back(model_read(e_a));
         m_irq = |(m_flag & m_mask);
         for (int i = 0; i < N; i++) begin
            e_evt = done_tb[i] && !m_done_prev[i];
            e_set = 1'b0;
            if (e_wr && e_a == 4'h0 && e_d[i]) begin
               m_busy[i] = 1'b1;
               m_s[i]    = m_j;
            end else if (m_busy[i]) begin
               if ((e_wr && e_a == 4'h2 && e_d[i]) || e_evt) begin
                  m_busy[i] = 1'b0;
               end else if (e_tick && m_tmo != 0 &&
                            ticks_between(m_s[i], m_j) == int'(m_tmo)) begin
                  m_busy[i] = 1'b0;
                  e_set     = 1'b1;
               end
            end
            if (e_wr && e_a == 4'h0 && e_d[i])      m_hist[i] = 1'b1;
            else if (e_wr && e_a == 4'h4 && e_d[i]) m_hist[i] = 1'b0;
            if (e_set)                              m_flag[i] = 1'b1;
            else if (e_wr && e_a == 4'h6 && e_d[i]) m_flag[i] = 1'b0;
            m_done_prev[i] = done_tb[i];
         end
         if (e_wr && e_a == 4'h7) m_tmo  = e_d;
         if (e_wr && e_a == 4'h8) m_mask = e_d[N-1:0];
      end
   end

   // Monitor: compares live outputs every cycle and pops the scoreboard on DV.
   always @(negedge clk) begin
      if (mon_en) begin
         check("ac_start", 32'(ac_start), 32'(m_busy));
         check("irq", 32'(irq), 32'(m_irq));
         check("rd_dv", 32'(bus.o_Bus_Rd_DV), 32'(m_dv));
         if (bus.o_Bus_Rd_DV === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL rd_unexpected: data %0h with nothing expected", bus.o_Bus_Rd_Data);
            end else begin
               check("rd_data", 32'(bus.o_Bus_Rd_Data), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // Drivers: each access occupies exactly one clock and starts/ends at a negedge.
   task automatic access(input logic wr, input logic [3:0] a, input logic [7:0] d);
      bus.i_Bus_CS      = 1'b1;
      bus.i_Bus_Wr_Rd_n = wr;
      bus.i_Bus_Addr8   = a;
      bus.i_Bus_Wr_Data = d;
      @(negedge clk);
      bus.i_Bus_CS = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      access(1'b1, a, d);
   endtask

   task automatic rd(input logic [3:0] a);
      access(1'b0, a, 8'h00);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Counts clocks ch0 stays busy after a start that was just sampled.
   task automatic measure_busy(input string name);
      int n = 0;
      for (int i = 0; i < 40; i++) begin
         if (ac_start[0] !== 1'b1) break;
         n++;
         @(negedge clk);
      end
      n_checks++;
      if (n < (3 - 1) * DIV + 1 || n > 3 * DIV) begin
         n_err++;
         $display("FAIL %s: busy for %0d clocks, expected %0d..%0d", name, n, (3 - 1) * DIV + 1, 3 * DIV);
      end
   endtask

   // Waits until the model says ch0 expires on the coming edge.
   task automatic wait_expiry_next(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (m_busy[0] && ((m_j + 1) % DIV == 0) && m_tmo != 0 &&
             ticks_between(m_s[0], m_j + 1) == int'(m_tmo)) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   bit         ok;
   logic [3:0] addrs [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF};

   initial begin
      rst_l = 1'b0;
      bus.i_Bus_CS = 1'b0; bus.i_Bus_Wr_Rd_n = 1'b0;
      bus.i_Bus_Addr8 = '0; bus.i_Bus_Wr_Data = '0;
      done_tb = '0;
      idle(3);
      rst_l  = 1'b1;
      mon_en = 1'b1;
      rd(4'h7); rd(4'h1);

      // Basic start / done / history
      wr(4'h0, 8'h01); rd(4'h1);
      done_tb[0] = 1'b1; idle(1); done_tb[0] = 1'b0;
      rd(4'h3); wr(4'h4, 8'h01); rd(4'h3);

      // Level done does not complete a new event; a fresh edge does
      done_tb[1] = 1'b1; idle(2);
      wr(4'h0, 8'h02); idle(3); rd(4'h1);
      done_tb[1] = 1'b0; idle(1); done_tb[1] = 1'b1; idle(1); done_tb[1] = 1'b0;
      rd(4'h1);
      wr(4'h0, 8'h02); idle(2); wr(4'h2, 8'h02); rd(4'h1); rd(4'h5);

      // Timeout with a short timeout value and interrupt mask
      wr(4'h7, 8'd3); wr(4'h8, 8'h01);
      wr(4'h0, 8'h01);
      measure_busy("tmo_window");
      rd(4'h5); idle(2);
      wr(4'h6, 8'h01); rd(4'h5); idle(2);

      // Flag clear on the same edge as expiry: the set wins
      wr(4'h0, 8'h01);
      wait_expiry_next(ok);
      check("expiry_reached", 32'(ok), 32'd1);
      wr(4'h6, 8'h01); rd(4'h5); idle(1);
      wr(4'h6, 8'h01); idle(1);

      // Retrigger after two ticks restarts the watchdog
      wr(4'h0, 8'h01);
      for (int i = 0; i < 40 && ticks_between(m_s[0], m_j) < 2; i++) @(negedge clk);
      check("retrigger_point", 32'(ticks_between(m_s[0], m_j)), 32'd2);
      wr(4'h0, 8'h01);
      measure_busy("tmo_retrigger");
      wr(4'h6, 8'h01);

      // Start together with a done edge keeps the channel busy
      wr(4'h0, 8'h01); idle(2);
      done_tb[0] = 1'b1; wr(4'h0, 8'h01); done_tb[0] = 1'b0;
      rd(4'h1); wr(4'h2, 8'h01);

      // Timeout value 0 disables the watchdog
      wr(4'h7, 8'd0); wr(4'h0, 8'h01); idle(60); rd(4'h1); rd(4'h5); wr(4'h2, 8'h01);

      // Unused bits and unmapped offsets
      wr(4'h0, 8'hFF); rd(4'h1); rd(4'hF); rd(4'h0); wr(4'h8, 8'hFF); rd(4'h8);
      wr(4'h2, 8'hFF); wr(4'h8, 8'h01);

      // Reset in the middle of a counting event
      wr(4'h7, 8'd5); wr(4'h0, 8'h01); idle(6);
      rst_l = 1'b0; idle(1); rst_l = 1'b1;
      rd(4'h7); rd(4'h5); rd(4'h1); rd(4'h8);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] a;
         logic [7:0] d;
         if ($urandom_range(0, 7) == 0) done_tb = done_tb ^ N'($urandom_range(0, 3));
         if ($urandom_range(0, 9) < 4) begin
            idle(1);
         end else begin
            a = addrs[$urandom_range(0, 9)];
            d = 8'($urandom);
            if (a == 4'h7) d = 8'($urandom_range(0, 6));
            if (a == 4'h0 && $urandom_range(0, 3) != 0) d = 8'h00;
            access(1'($urandom_range(0, 1)), a, d);
         end
      end

      done_tb = '0;
      idle(3);
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
